// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with valid/ready word input
// Purpose:
//   Serialises a parallel word as start(0), DATA_BITS data bits LSB first,
//   an optional parity bit and STOP_BITS stop(1) bits. Every serial bit is held
//   for CLKS_PER_BIT clock cycles. The line idles high.
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   tx_data        word to send, latched when tx_valid && tx_ready
//   tx_valid       tx_data is valid
//   tx_ready       a word can be accepted this cycle
//   outgoing_data  registered serial line
//   busy           a frame is in progress
//   done           one-cycle pulse in the final cycle of the last stop bit
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 outgoing_data,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // The index counts data bits and is reused to count stop bits.
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST       = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST  = IW'(STOP_BITS - 1);
  localparam logic          PAR_FLIP       = (PARITY_ODD != 0);
  localparam logic          HAS_PAR        = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;

  logic bit_end;
  logic last_stop_cycle;
  logic accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    line_d  = 1'b1;

    bit_end         = (cnt_q == CNT_LAST);
    last_stop_cycle = (state_q == S_STOP) && (idx_q == IDX_STOP_LAST) && bit_end;
    // The final stop cycle doubles as an accept slot so frames can abut.
    tx_ready        = (state_q == S_IDLE) || last_stop_cycle;
    done            = last_stop_cycle;
    busy            = (state_q != S_IDLE);
    accept          = tx_valid && tx_ready;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_DATA_LAST) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = S_START;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = tx_data;
      par_d   = (^tx_data) ^ PAR_FLIP;
    end

    // Line value is derived from the next state so the registered output
    // lines up with the state register.
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
    end
  end

  assign outgoing_data = line_q;

endmodule
